// File: rtl/red_led_fader.sv
`default_nettype none
// ============================================================================
// Module      : red_led_fader
// Description : PWM fade stage for the red LED bank. Each LED steps its
//               brightness once per PWM period toward its pattern bit.
//               Define RED_LED_FADER_INSTANT_EN to compile fading out.
// Revision    : 1.0  initial release
// ============================================================================
module red_led_fader #(
  parameter int PRESCALE = 2,
  parameter int PWM_BITS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] pattern,
  output logic [7:0] led_out,
  output logic       busy
);

  logic [7:0] r_led_out;

  assign led_out = r_led_out;

`ifdef RED_LED_FADER_INSTANT_EN

  // Levels collapse to full on/off, so the drive is simply the registered pattern.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_led_out <= 8'h00;
    end else begin
      r_led_out <= pattern;
    end
  end

  assign busy = 1'b0;

`else

  localparam int                  c_PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [c_PRE_W-1:0]  c_PRE_LAST = c_PRE_W'(PRESCALE - 1);
  localparam logic [PWM_BITS-1:0] c_MAX      = {PWM_BITS{1'b1}};

  logic [c_PRE_W-1:0]  r_pre_cnt;
  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic [PWM_BITS-1:0] r_lvl [8];
  logic                r_busy;
  logic                w_tick;
  logic                w_period_end;
  logic [7:0]          w_led_nxt;
  logic [7:0]          w_mismatch;

  assign w_tick       = (r_pre_cnt == c_PRE_LAST);
  assign w_period_end = w_tick && (r_pwm_cnt == c_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pre_cnt <= '0;
      r_pwm_cnt <= '0;
    end else begin
      r_pre_cnt <= w_tick ? '0 : r_pre_cnt + 1'b1;
      if (w_tick) begin
        r_pwm_cnt <= r_pwm_cnt + 1'b1;
      end
    end
  end

  // Levels move one step per period and saturate at both ends.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        r_lvl[i] <= '0;
      end
    end else if (w_period_end) begin
      for (int i = 0; i < 8; i++) begin
        if (pattern[i] && (r_lvl[i] != c_MAX)) begin
          r_lvl[i] <= r_lvl[i] + 1'b1;
        end else if (!pattern[i] && (r_lvl[i] != '0)) begin
          r_lvl[i] <= r_lvl[i] - 1'b1;
        end
      end
    end
  end

  generate
    for (genvar i = 0; i < 8; i++) begin : g_led
      assign w_led_nxt[i]  = (r_lvl[i] == c_MAX) || (r_lvl[i] > r_pwm_cnt);
      assign w_mismatch[i] = (r_lvl[i] != (pattern[i] ? c_MAX : '0));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      r_led_out <= 8'h00;
      r_busy    <= 1'b0;
    end else begin
      r_led_out <= w_led_nxt;
      r_busy    <= |w_mismatch;
    end
  end

  assign busy = r_busy;

`endif

endmodule
`default_nettype wire

// File: tb/tb_red_led_fader.sv
`default_nettype none
// ============================================================================
// Module      : tb_red_led_fader
// Description : Directed and randomized bench for red_led_fader against a
//               period-arithmetic reference model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_red_led_fader;

  localparam int P      = 2;
  localparam int BITS   = 4;
  localparam int MAXV   = (1 << BITS) - 1;
  localparam int PERIOD = P * (MAXV + 1);

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] pattern = 8'h00;
  logic [7:0] led_out;
  logic       busy;

  int vectors = 0;
  int miscompares = 0;

  // Model: cycles since reset within one period, and each LED's brightness.
  int m_n = 0;
  int m_lvl [8];

  logic [7:0] exp_led;
  logic       exp_busy;

  always #5 clk = ~clk;

  red_led_fader #(.PRESCALE(P), .PWM_BITS(BITS)) dut (
    .clk     (clk),
    .reset   (reset),
    .pattern (pattern),
    .led_out (led_out),
    .busy    (busy)
  );

  task automatic cyc(input logic r, input logic [7:0] pat, input string tag);
    int pwm;
    @(negedge clk);
    reset   = r;
    pattern = pat;
    if (r) begin
      exp_led  = 8'h00;
      exp_busy = 1'b0;
    end else begin
`ifdef RED_LED_FADER_INSTANT_EN
      exp_led  = pat;
      exp_busy = 1'b0;
`else
      pwm      = (m_n / P) % (MAXV + 1);
      exp_busy = 1'b0;
      for (int i = 0; i < 8; i++) begin
        exp_led[i] = (m_lvl[i] == MAXV) || (m_lvl[i] > pwm);
        if (m_lvl[i] != (pat[i] ? MAXV : 0)) exp_busy = 1'b1;
      end
`endif
    end
    @(posedge clk);
    #1;
    if (r) begin
      m_n = 0;
      for (int i = 0; i < 8; i++) m_lvl[i] = 0;
    end else begin
      if (m_n == PERIOD - 1) begin
        for (int i = 0; i < 8; i++) begin
          if (pat[i] && m_lvl[i] < MAXV) m_lvl[i] = m_lvl[i] + 1;
          else if (!pat[i] && m_lvl[i] > 0) m_lvl[i] = m_lvl[i] - 1;
        end
      end
      m_n = (m_n + 1) % PERIOD;
    end
    vectors++;
    assert (led_out === exp_led) else begin
      miscompares++;
      $error("FAIL %s led_out observed %h expected %h", tag, led_out, exp_led);
    end
    assert (busy === exp_busy) else begin
      miscompares++;
      $error("FAIL %s busy observed %b expected %b", tag, busy, exp_busy);
    end
  endtask

  initial begin
    int guard;
    int duty;
    logic [7:0] rpat;
    int len;

    for (int i = 0; i < 8; i++) m_lvl[i] = 0;

    // Reset held with all targets on.
    repeat (3) cyc(1'b1, 8'hFF, "reset");
    repeat (2) cyc(1'b0, 8'h00, "post_reset");

    // Full ramp of LED 0, then steady full-on.
    for (int k = 0; k < 16 * PERIOD + 8; k++) cyc(1'b0, 8'h01, "ramp_up");

    // Duty with LED 3 at level 4 for one whole period.
    guard = 0;
    while (m_lvl[3] != 4 && guard < 2000) begin
      cyc(1'b0, 8'h09, "duty_wait");
      guard++;
    end
    assert (m_lvl[3] == 4) else begin
      miscompares++;
      $error("FAIL duty_wait timeout level %0d expected %0d", m_lvl[3], 4);
    end
    duty = 0;
    for (int k = 0; k < PERIOD; k++) begin
      cyc(1'b0, 8'h09, "duty");
      if (led_out[3] === 1'b1) duty++;
    end
    vectors++;
    assert (duty == 4 * P) else begin
      miscompares++;
      $error("FAIL duty_count observed %0d expected %0d", duty, 4 * P);
    end

    // Reversal of LED 7 at level 6.
    guard = 0;
    while (m_lvl[7] != 6 && guard < 2000) begin
      cyc(1'b0, 8'h80, "rev_wait");
      guard++;
    end
    assert (m_lvl[7] == 6) else begin
      miscompares++;
      $error("FAIL rev_wait timeout level %0d expected %0d", m_lvl[7], 6);
    end
    for (int k = 0; k < 8 * PERIOD; k++) cyc(1'b0, 8'h00, "reversal");

    // Reset mid-ramp with LED 2 at level 9.
    guard = 0;
    while (m_lvl[2] != 9 && guard < 2000) begin
      cyc(1'b0, 8'h04, "mid_wait");
      guard++;
    end
    assert (m_lvl[2] == 9) else begin
      miscompares++;
      $error("FAIL mid_wait timeout level %0d expected %0d", m_lvl[2], 9);
    end
    cyc(1'b1, 8'h04, "reset_mid");
    for (int k = 0; k < 3 * PERIOD; k++) cyc(1'b0, 8'h04, "restart");

    // Random patterns held for random lengths, with occasional resets.
    for (int s = 0; s < 60; s++) begin
      rpat = 8'($urandom);
      len  = $urandom_range(1, 100);
      if ($urandom_range(0, 19) == 0) cyc(1'b1, rpat, "rand_reset");
      for (int k = 0; k < len; k++) cyc(1'b0, rpat, "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/red_led_fader.md
# red_led_fader

Downstream PWM fade stage for the red LED bank. It takes the static 8-bit pattern driven by the red LED PIO's `out_port` and drives the physical LED pins. Each LED ramps its brightness up or down in discrete steps toward its pattern bit instead of switching instantly. The block sits between the PIO output register and the board pins, in the same clock domain as the PIO.

## Interface
- `PRESCALE`, default 2: clk cycles per PWM tick; legal range 1..65535.
- `PWM_BITS`, default 4: width of the per-LED brightness level and of the PWM counter; legal range 2..8.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset. One clock; reset is synchronous and active-high.
- `pattern`  in  8  target on/off per LED; connected to the PIO `out_port`.
- `led_out`  out  8  PWM-modulated LED drive; registered.
- `busy`  out  1  high while any LED level differs from its target; registered.

## Operation
- Prescaler `pre_cnt` counts 0..PRESCALE-1 and wraps. `tick` = (`pre_cnt` == PRESCALE-1).
- PWM counter `pwm_cnt` is PWM_BITS wide and increments on `tick`. It wraps from MAX = 2^PWM_BITS-1 to 0.
- PWM period = PRESCALE × 2^PWM_BITS cycles.
- `period_end` = `tick` && `pwm_cnt` == MAX.
- Each LED i has a level `lvl[i]` (PWM_BITS wide, range 0..MAX) and an implicit state:
  - OFF: `lvl`=0 and `pattern[i]`=0
  - RISING: `pattern[i]`=1 and `lvl`<MAX
  - ON: `lvl`=MAX and `pattern[i]`=1
  - FALLING: `pattern[i]`=0 and `lvl`>0
- On `period_end`, each RISING LED increments `lvl` by 1 and each FALLING LED decrements it by 1. `lvl` saturates at 0 and at MAX and never wraps.
- Target reversal mid-ramp: the LED's direction changes at the next `period_end`, starting from its current `lvl`. There is no restart from an end point.
- `pattern` is sampled every cycle. Only its value at a `period_end` edge affects the step direction.
- Drive rule:
  - `led_out[i]` next = 1 if `lvl[i]` == MAX, else (`lvl[i]` > `pwm_cnt`).
  - MAX gives 100% duty; 0 gives 0%.
- `busy` next = OR over i of (`lvl[i]` != (`pattern[i]` ? MAX : 0)).

## Timing
- Reset values: `pre_cnt`=0, `pwm_cnt`=0, all `lvl`=0, `led_out`=0x00, `busy`=0.
- Reset asserted mid-ramp clears all state on that edge. The first tick after deassertion occurs PRESCALE cycles later.
- `led_out` and `busy` lag the internal `lvl`/`pwm_cnt` by exactly 1 cycle.
- A full ramp 0→MAX takes MAX periods:
  - from the `pattern` change to the first step: up to 1 period;
  - total ≤ (MAX+1) × period cycles.
- With PRESCALE=1, `tick` is high every cycle.
- All 8 LEDs step on the same `period_end` edge; there is no staggering.

## Configuration
- `RED_LED_FADER_INSTANT_EN`:
  - When defined, fading is compiled out. `lvl[i]` loads MAX or 0 directly from `pattern[i]` every cycle.
  - `led_out` = registered `pattern`, so latency is 1 cycle.
  - `busy` is tied to 0, and the prescaler and PWM counter are removed.
- When not defined: full fade behaviour as above.

## Test plan
Defaults for all scenarios: PRESCALE=2, PWM_BITS=4 (MAX=15, period 32 cycles).

- Reset: hold `reset` 3 cycles with `pattern`=0xFF → `led_out`=0x00 and `busy`=0 on every cycle during reset and on the first cycle after it.
- Ramp up: `pattern` 0x00→0x01 at cycle 0 after reset → `busy`=1 from cycle 2. `lvl[0]` reaches 15 after 15 `period_end`s (~480 cycles). Then `led_out[0]` is constantly 1 and `busy`=0.
- Duty check: hold `lvl[3]`=4 → `led_out[3]` is high for exactly 8 of every 32 cycles (4 PWM counts × PRESCALE).
- Reversal: `pattern`=0x80 until `lvl[7]`=6, then 0x00 → `lvl[7]` goes 6,5,…,0 on successive `period_end`s, with no step above 6.
- Reset mid-ramp: assert `reset` 1 cycle while `lvl[2]`=9 → the next cycle shows `led_out`=0x00. With `pattern`=0x04 still held, the ramp restarts from 0.
- Instant build: define `RED_LED_FADER_INSTANT_EN`, write `pattern`=0xA5 → `led_out`=0xA5 exactly 1 cycle later, and `busy` stays 0 throughout.
